line_window_buffer: RTL and testbench

- Parametrised multi-row line buffer for the CNN convolution front end; generalises the single-line FIFO delay stage.
- Stores KSIZE-1 image rows in internal circular line memories with no vendor FIFO IP.
- For each accepted pixel, emits one vertical column of KSIZE pixels, oldest row first, which feeds the KSIZE x KSIZE window shift register.
- Tracks column and row position and flags end-of-line, so downstream window logic needs no counters of its own.

---
 rtl/line_window_buffer.sv | 114 +++++++++++
 tb/tb_line_window_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/line_window_buffer.sv
// Multi-row circular line buffer emitting one KSIZE-tall pixel column per accepted pixel.
// Optional build macro LB_ZERO_PAD_EN: output from row 0 with unfilled rows forced to zero.
module line_window_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 10,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned CNT_W  = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       din,
  input  logic                    valid_in,
  input  logic                    sof,
  output logic [KSIZE*DATA_W-1:0] dout,
  output logic                    valid_out,
  output logic [CNT_W-1:0]        col_out,
  output logic                    eol_out
);

  localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] LastCol = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LastRow = CNT_W'(KSIZE - 1);

  logic [DATA_W-1:0]       mem_q [KSIZE-1][IMG_W];
  logic [DATA_W-1:0]       rd    [KSIZE-1];
  logic [CNT_W-1:0]        col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0]        col_eff, row_eff;
  logic [AW-1:0]           idx;
  logic [KSIZE*DATA_W-1:0] dout_q, dout_d;
  logic                    valid_q, valid_d;
  logic                    eol_q, eol_d;
  logic [CNT_W-1:0]        col_out_q, col_out_d;

  // sof forces the current pixel to frame position (0,0) regardless of counter state
  assign col_eff = sof ? '0 : col_q;
  assign row_eff = sof ? '0 : row_q;
  assign idx     = col_eff[AW-1:0];

  always_comb begin
    for (int j = 0; j < int'(KSIZE) - 1; j++) begin
      rd[j] = mem_q[j][idx];
    end
  end

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    dout_d    = dout_q;
    col_out_d = col_out_q;
    valid_d   = 1'b0;
    eol_d     = 1'b0;
    if (valid_in) begin
      if (col_eff == LastCol) begin
        col_d = '0;
        row_d = (row_eff == LastRow) ? row_eff : row_eff + CNT_W'(1);
      end else begin
        col_d = col_eff + CNT_W'(1);
        row_d = row_eff;
      end
      dout_d[DATA_W-1:0] = din;
      for (int j = 1; j < int'(KSIZE); j++) begin
`ifdef LB_ZERO_PAD_EN
        dout_d[j*DATA_W +: DATA_W] = (row_eff < CNT_W'(j)) ? '0 : rd[j-1];
`else
        dout_d[j*DATA_W +: DATA_W] = rd[j-1];
`endif
      end
      col_out_d = col_eff;
      eol_d     = (col_eff == LastCol);
`ifdef LB_ZERO_PAD_EN
      valid_d   = 1'b1;
`else
      valid_d   = (row_eff >= LastRow);
`endif
    end else if (sof) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      dout_q    <= '0;
      col_out_q <= '0;
      valid_q   <= 1'b0;
      eol_q     <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      dout_q    <= dout_d;
      col_out_q <= col_out_d;
      valid_q   <= valid_d;
      eol_q     <= eol_d;
    end
  end

  // Line memories are never cleared; stale contents are hidden by valid_out gating
  always_ff @(posedge clk) begin
    if (valid_in && !rst) begin
      mem_q[0][idx] <= din;
      for (int j = 1; j < int'(KSIZE) - 1; j++) begin
        mem_q[j][idx] <= rd[j-1];
      end
    end
  end

  assign dout      = dout_q;
  assign valid_out = valid_q;
  assign col_out   = col_out_q;
  assign eol_out   = eol_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed, table-driven bench for line_window_buffer at IMG_W=4, KSIZE=3, DATA_W=8.
module tb_line_window_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        valid_in;
  logic        sof;
  logic [23:0] dout;
  logic        valid_out;
  logic [8:0]  col_out;
  logic        eol_out;

  int total = 0;
  int bad   = 0;

  line_window_buffer #(
    .DATA_W(8),
    .IMG_W (4),
    .KSIZE (3),
    .CNT_W (9)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .valid_in (valid_in),
    .sof      (sof),
    .dout     (dout),
    .valid_out(valid_out),
    .col_out  (col_out),
    .eol_out  (eol_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          s;
    logic [7:0]  d;
    bit          ev;
    bit          cd;
    logic [23:0] edout;
    logic [8:0]  ecol;
    bit          eeol;
  } vec_t;

  vec_t tbl [24];
  int   n = 0;

  task automatic add(input bit v, input bit s, input logic [7:0] d, input bit ev, input bit cd,
                     input logic [23:0] edout, input logic [8:0] ecol, input bit eeol);
    tbl[n] = '{v, s, d, ev, cd, edout, ecol, eeol};
    n++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the edge that captured them
  task automatic drive(input bit r, input bit v, input bit s, input logic [7:0] d);
    @(negedge clk);
    rst      = r;
    valid_in = v;
    sof      = s;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " dout"}, dout, 0);
    check({tag, " valid_out"}, valid_out, 0);
    check({tag, " col_out"}, col_out, 0);
    check({tag, " eol_out"}, eol_out, 0);
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    sof      = 1'b0;
    din      = '0;

`ifdef LB_ZERO_PAD_EN
    for (int i = 1; i <= 13; i++) begin
      int r;
      int c;
      logic [7:0] s2;
      logic [7:0] s1;
      r  = (i - 1) / 4;
      c  = (i - 1) % 4;
      s2 = (r >= 2) ? 8'(i - 8) : 8'd0;
      s1 = (r >= 1) ? 8'(i - 4) : 8'd0;
      add(1, i == 1, 8'(i), 1, 1, {s2, s1, 8'(i)}, 9'(c), c == 3);
    end
`else
    for (int i = 1; i <= 8; i++) begin
      add(1, i == 1, 8'(i), 0, 0, 24'd0, 9'((i - 1) % 4), ((i - 1) % 4) == 3);
    end
    add(1, 0, 8'd9,  1, 1, {8'd1, 8'd5, 8'd9},  9'd0, 0);
    add(1, 0, 8'd10, 1, 1, {8'd2, 8'd6, 8'd10}, 9'd1, 0);
    for (int i = 0; i < 3; i++) begin
      add(0, 0, 8'hee, 0, 1, {8'd2, 8'd6, 8'd10}, 9'd1, 0);
    end
    add(1, 0, 8'd11, 1, 1, {8'd3, 8'd7, 8'd11}, 9'd2, 0);
    add(1, 0, 8'd12, 1, 1, {8'd4, 8'd8, 8'd12}, 9'd3, 1);
    add(1, 0, 8'd13, 1, 1, {8'd5, 8'd9, 8'd13}, 9'd0, 0);
`endif

    drive(1, 0, 0, 8'd0);
    drive(1, 0, 0, 8'd0);
    check_all_zero("reset");

    for (int i = 0; i < n; i++) begin
      drive(0, tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d valid_out", i), valid_out, tbl[i].ev);
      check($sformatf("vec%0d col_out", i), col_out, tbl[i].ecol);
      check($sformatf("vec%0d eol_out", i), eol_out, tbl[i].eeol);
      if (tbl[i].cd) check($sformatf("vec%0d dout", i), dout, tbl[i].edout);
    end

`ifndef LB_ZERO_PAD_EN
    // Reset while a pixel is offered wins over the pixel
    drive(1, 1, 0, 8'd14);
    check_all_zero("midrst");

    for (int k = 0; k <= 8; k++) begin
      drive(0, 1, k == 0, 8'(100 + k));
      check($sformatf("restart%0d valid_out", k), valid_out, k == 8);
    end
    check("restart dout", dout, {8'd100, 8'd104, 8'd108});
    check("restart col_out", col_out, 0);

    for (int k = 1; k <= 6; k++) drive(0, 1, k == 1, 8'(k));
    drive(0, 0, 1, 8'd0);
    check("sof_alone valid_out", valid_out, 0);
    check("sof_alone eol_out", eol_out, 0);
    for (int k = 0; k <= 8; k++) begin
      drive(0, 1, 0, 8'(20 + k));
      check($sformatf("after_sof%0d valid_out", k), valid_out, k == 8);
    end
    check("after_sof dout", dout, {8'd20, 8'd24, 8'd28});
    check("after_sof col_out", col_out, 0);
    check("after_sof eol_out", eol_out, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
